// File: rtl/frv_leak_scrub_pkg.sv
// ============================================================================
// frv_leak_scrub_pkg : shared constants for the leakage-fence GPR scrubber
// Rev 1.0
// ============================================================================
`default_nettype none

package frv_leak_scrub_pkg;

    localparam int FRV_XLEN = 32;
    localparam int FRV_XL   = FRV_XLEN - 1;

    // Scrub FSM encodings
    localparam logic [1:0] FRV_SCRUB_IDLE  = 2'd0;
    localparam logic [1:0] FRV_SCRUB_SCRUB = 2'd1;
    localparam logic [1:0] FRV_SCRUB_DONE  = 2'd2;

    // ALCFG bit that enables the GPR scrub
    localparam int FRV_ALCFG_GPR = 0;

endpackage

`default_nettype wire

// File: rtl/frv_leak_scrub.sv
// ============================================================================
// frv_leak_scrub : on a leakage fence, overwrites x1..x(NREGS-1) with PRNG
//                  words (or zero in weak builds) and stalls the pipeline.
// Rev 1.0
// ============================================================================
`default_nettype none

module frv_leak_scrub
    import frv_leak_scrub_pkg::*;
#(
    parameter int XLEN                 = FRV_XLEN,
    parameter int NREGS                = 32,
    parameter bit XC_CLASS_LEAK_STRONG = 1'b1
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            fence_req,
    input  logic            cfg_gpr_en,
    input  logic [XLEN-1:0] leak_prng,
    output logic            leak_fence,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_wgrant,
    output logic            scrub_busy,
    output logic            fence_ack
);

    localparam int             IW       = $clog2(NREGS);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NREGS - 1);
    localparam logic [IW-1:0]  IDX_FIRST = IW'(1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    logic          in_scrub;

    assign in_scrub = (state_q == FRV_SCRUB_SCRUB);

    // Address and data come straight from state, so they stay put while
    // writeback holds the port and the PRNG only steps on a granted write.
    assign rf_wen     = in_scrub;
    assign rf_waddr   = in_scrub ? 5'(idx_q) : 5'd0;
    assign rf_wdata   = (in_scrub && XC_CLASS_LEAK_STRONG) ? leak_prng : '0;
    assign leak_fence = rf_wen & rf_wgrant & XC_CLASS_LEAK_STRONG;
    assign scrub_busy = (state_q != FRV_SCRUB_IDLE);
    assign fence_ack  = (state_q == FRV_SCRUB_DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            FRV_SCRUB_IDLE: begin
                if (fence_req) begin
                    idx_d   = IDX_FIRST;
                    state_d = cfg_gpr_en ? FRV_SCRUB_SCRUB : FRV_SCRUB_DONE;
                end
            end
            FRV_SCRUB_SCRUB: begin
                // Terminal compare exits before the index could wrap.
                if (rf_wgrant) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = FRV_SCRUB_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FRV_SCRUB_DONE: begin
                state_d = FRV_SCRUB_IDLE;
            end
            default: begin
                state_d = FRV_SCRUB_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= FRV_SCRUB_IDLE;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/frv_leak_scrub.md
Name: frv_leak_scrub

Overview:
- Leakage-fence register scrubber for the FRV core.
- On a leakage-fence request it walks the GPR file (x1..x(NREGS-1)) and overwrites each register with a fresh PRNG word, or with zero in weak mode.
- Each accepted write pulses leak_fence, which steps the leakage PRNG. The block is therefore the consumer of leak_prng and the producer of leak_fence.
- It sits beside writeback and stalls the pipeline while active.

Parameters:
- XLEN, 32, data width; XL = XLEN-1.
- NREGS, 32, number of architectural GPRs; x0 is never written.
- XC_CLASS_LEAK_STRONG, 1, 1 = write leak_prng values; 0 = write zero and never pulse leak_fence.

Ports:
- g_clk  input  1  core clock.
- g_resetn  input  1  synchronous active-low reset.
- fence_req  input  1  leakage fence issued; held high until fence_ack.
- cfg_gpr_en  input  1  ALCFG bit enabling GPR scrub; sampled only on request acceptance.
- leak_prng  input  XLEN  current PRNG value.
- leak_fence  output  1  PRNG step strobe.
- rf_wen  output  1  register-file write request.
- rf_waddr  output  5  write address.
- rf_wdata  output  XLEN  write data.
- rf_wgrant  input  1  write port granted this cycle; writeback has priority.
- scrub_busy  output  1  stall request to pipeline.
- fence_ack  output  1  one-cycle completion pulse.

Behaviour:
- Reset (g_resetn low at a clock edge):
  - state=IDLE, idx=1.
  - All outputs 0: rf_wen, leak_fence, scrub_busy, fence_ack, rf_waddr, rf_wdata.
- FSM states: IDLE, SCRUB, DONE (2-bit encoding).
- IDLE:
  - fence_req=1 and cfg_gpr_en=1 -> SCRUB, idx<=1.
  - fence_req=1 and cfg_gpr_en=0 -> DONE (no writes).
  - Otherwise stay in IDLE.
- SCRUB:
  - scrub_busy=1, rf_wen=1, rf_waddr=idx[4:0].
  - rf_wdata = leak_prng if STRONG, else 0.
  - Combinational: leak_fence = rf_wen & rf_wgrant & XC_CLASS_LEAK_STRONG.
  - On rf_wgrant:
    - If idx == NREGS-1 -> DONE.
    - Else idx<=idx+1.
  - On !rf_wgrant: hold idx; rf_waddr and rf_wdata stay stable. The PRNG does not step without a grant, so each register receives a distinct PRNG word.
- DONE:
  - fence_ack=1 and scrub_busy=1 for exactly one cycle, then -> IDLE.
  - fence_req is ignored in DONE.
  - A new request is accepted no earlier than the cycle after DONE.
- Latency:
  - Disabled fence: ack 1 cycle after acceptance.
  - Enabled fence with continuous grant: NREGS-1 write cycles, then ack. At NREGS=32, fence_req sampled at edge 0 gives writes in cycles 1..31 and ack in cycle 32.
- idx width is clog2(NREGS). No wrap past NREGS-1: the terminal compare exits SCRUB before any increment would wrap.
- Reset mid-scrub: abort immediately to IDLE with no fence_ack. Registers already written keep their new values.
- fence_req dropped during SCRUB is a protocol violation; the scrub still completes. The bench asserts it never happens.
- In IDLE, fence_req=1 together with rf_wgrant has no effect beyond acceptance.

Decomposition:
- Shared package / frv_common.vh:
  - XLEN/XL constants.
  - Scrub FSM state encodings FRV_SCRUB_IDLE/SCRUB/DONE.
  - ALCFG bit index FRV_ALCFG_GPR.
- No sub-module needed; FSM and counter are flat.
- Top-level wiring: leak_fence -> frv_leak.leak_fence; frv_leak.leak_prng -> leak_prng.

Test Plan:
1. Reset then idle: hold g_resetn=0 two cycles, release, fence_req=0 -> all outputs 0 for 10 cycles.
2. Full strong scrub:
   - Stimulus: cfg_gpr_en=1, rf_wgrant=1, fence_req pulse held to ack, with a PRNG model seeded 32'hABCDEF37.
   - Response: 31 writes with rf_waddr 1..31 in order, each rf_wdata equal to the model's successive values, 31 leak_fence pulses, fence_ack exactly at cycle 32, scrub_busy high in cycles 1..32.
3. Disabled fence: cfg_gpr_en=0, fence_req -> no rf_wen, no leak_fence, fence_ack the next cycle.
4. Grant backpressure:
   - Stimulus: rf_wgrant low for 3 cycles while rf_waddr=5.
   - Response: addr/data stable and leak_fence=0 during the stall; write x5 completes on the grant; total time = 32 + 3 cycles.
5. Reset mid-operation: assert g_resetn=0 while idx=10 -> next cycle IDLE, outputs 0, no fence_ack; a subsequent fence restarts at x1.
6. Weak build (XC_CLASS_LEAK_STRONG=0): full scrub -> all 31 rf_wdata=0, leak_fence never asserts, ack at cycle 32.
